stream_source: RTL and testbench

//  Parametrised, file-backed word-stream source for the brainfuck benches.

---
 rtl/stream_source_pkg.sv | 19 +
 rtl/stream_source_if.sv | 35 +++
 rtl/stream_gap_lfsr.sv | 27 ++
 rtl/stream_source.sv | 118 +++++++++++
 tb/tb_stream_source.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_source_pkg.sv
// Shared types and constants for the word-stream source: FSM encoding and
// the gap-generator LFSR polynomial.
package stream_source_pkg;

    typedef enum logic [1:0] {
        ST_STREAM = 2'd0,
        ST_GAP    = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        lfsr_step = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/stream_source_if.sv
// Consumer-facing bundle of the stream source plus its image preload port
// and a debug view of the FSM state.
interface stream_source_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
);
    import stream_source_pkg::*;

    // Handshake: a word moves on a rising clk edge where valid_o && read_i;
    // read_i while valid_o=0 is ignored, and valid_o is held high until that
    // transfer or a rewind_i.
    logic              rewind_i;
    logic              read_i;
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic              done_o;
    logic [CNT_W-1:0]  count_o;
    state_t            state_o;

    logic              load_we_i;
    logic [ADDR_W-1:0] load_addr_i;
    logic [DATA_W-1:0] load_data_i;

    modport master (
        input  rewind_i, read_i, load_we_i, load_addr_i, load_data_i,
        output data_o, valid_o, done_o, count_o, state_o
    );

    modport slave (
        output rewind_i, read_i, load_we_i, load_addr_i, load_data_i,
        input  data_o, valid_o, done_o, count_o, state_o
    );

endinterface

// File: rtl/stream_gap_lfsr.sv
// 16-bit Galois LFSR that advances only when step_i is high; reset reseeds.
module stream_gap_lfsr
    import stream_source_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        step_i,
    output logic [15:0] state_o
);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (step_i) lfsr_d = lfsr_step(lfsr_q);
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) lfsr_q <= SEED;
        else       lfsr_q <= lfsr_d;
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/stream_source.sv
// Word-stream source: a preloaded image with a little-endian length header
// is presented word by word, with optional looping and LFSR-driven idle gaps.
module stream_source
    import stream_source_pkg::*;
#(
    parameter int          DATA_W    = 8,
    parameter int          ADDR_W    = 16,
    parameter int          HDR_WORDS = 2,
    parameter bit          LOOP      = 1'b0,
    parameter logic [3:0]  GAP_MASK  = 4'h0,
    parameter logic [15:0] SEED      = LFSR_DEFAULT_SEED
) (
    input  logic clk,
    input  logic rst_i,
    stream_source_if.master bus
);

    localparam int          DEPTH   = 2 ** ADDR_W;
    localparam int          CNT_W   = 8 * HDR_WORDS;
    localparam logic [31:0] MAX_LEN = 32'(DEPTH - HDR_WORDS);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (bus.load_we_i) mem_q[bus.load_addr_i] <= bus.load_data_i;
    end

    logic [31:0]       hdr_len;
    logic [ADDR_W-1:0] len;

    always_comb begin
        hdr_len = '0;
        for (int i = 0; i < HDR_WORDS; i++) begin
            hdr_len[8*i +: 8] = mem_q[ADDR_W'(i)][7:0];
        end
        len = (hdr_len > MAX_LEN) ? MAX_LEN[ADDR_W-1:0] : hdr_len[ADDR_W-1:0];
    end

    state_t            state_q, state_d, state_cur;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [3:0]        gap_q, gap_d;
    logic [15:0]       lfsr;
    logic [3:0]        gap_next;
    logic              xfer, last, valid;

    // Reset always lands in STREAM; an empty image is reported as DONE so the
    // reset-time outputs follow the header without a data-dependent reset value.
    assign state_cur = (state_q == ST_STREAM && len == '0) ? ST_DONE : state_q;
    assign valid     = (state_cur == ST_STREAM);
    assign xfer      = valid && bus.read_i;
    assign last      = (idx_q == len - ADDR_W'(1));
    assign gap_next  = 4'(lfsr_step(lfsr)) & GAP_MASK;

    stream_gap_lfsr #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .rst_i   (rst_i),
        .step_i  (xfer && !bus.rewind_i),
        .state_o (lfsr)
    );

    always_comb begin
        state_d = state_cur;
        idx_d   = idx_q;
        count_d = count_q;
        gap_d   = gap_q;
        if (bus.rewind_i) begin
            state_d = ST_STREAM;
            idx_d   = '0;
            count_d = '0;
            gap_d   = '0;
        end else begin
            case (state_cur)
                ST_STREAM: begin
                    if (bus.read_i) begin
                        count_d = count_q + CNT_W'(1);
                        if (last && !LOOP) begin
                            state_d = ST_DONE;
                            gap_d   = '0;
                        end else begin
                            idx_d = last ? '0 : idx_q + ADDR_W'(1);
                            if (gap_next != 4'd0) begin
                                state_d = ST_GAP;
                                gap_d   = gap_next;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    gap_d = gap_q - 4'd1;
                    if (gap_q == 4'd1) state_d = ST_STREAM;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_STREAM;
            idx_q   <= '0;
            count_q <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            gap_q   <= gap_d;
        end
    end

    assign bus.valid_o = valid;
    assign bus.done_o  = (state_cur == ST_DONE);
    assign bus.data_o  = valid ? mem_q[ADDR_W'(HDR_WORDS) + idx_q] : '0;
    assign bus.count_o = count_q;
    assign bus.state_o = state_cur;

endmodule

// File: tb/tb_stream_source.sv
// Self-checking bench for stream_source: four instances cover plain, looping,
// gapped and length-clipped configurations.
module tb_stream_source;
    import stream_source_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    stream_source_if #(.DATA_W(8), .ADDR_W(8),  .CNT_W(16)) bus_a ();
    stream_source_if #(.DATA_W(8), .ADDR_W(8),  .CNT_W(16)) bus_b ();
    stream_source_if #(.DATA_W(8), .ADDR_W(8),  .CNT_W(16)) bus_c ();
    stream_source_if #(.DATA_W(8), .ADDR_W(10), .CNT_W(24)) bus_d ();

    stream_source #(.ADDR_W(8)) dut_a (.clk(clk), .rst_i(rst), .bus(bus_a));
    stream_source #(.ADDR_W(8), .LOOP(1'b1)) dut_b (.clk(clk), .rst_i(rst), .bus(bus_b));
    stream_source #(.ADDR_W(8), .GAP_MASK(4'hF)) dut_c (.clk(clk), .rst_i(rst), .bus(bus_c));
    stream_source #(.ADDR_W(10), .HDR_WORDS(3)) dut_d (.clk(clk), .rst_i(rst), .bus(bus_d));

    function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
        ref_lfsr = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic clear_inputs();
        bus_a.read_i = 0; bus_a.rewind_i = 0; bus_a.load_we_i = 0; bus_a.load_addr_i = '0; bus_a.load_data_i = '0;
        bus_b.read_i = 0; bus_b.rewind_i = 0; bus_b.load_we_i = 0; bus_b.load_addr_i = '0; bus_b.load_data_i = '0;
        bus_c.read_i = 0; bus_c.rewind_i = 0; bus_c.load_we_i = 0; bus_c.load_addr_i = '0; bus_c.load_data_i = '0;
        bus_d.read_i = 0; bus_d.rewind_i = 0; bus_d.load_we_i = 0; bus_d.load_addr_i = '0; bus_d.load_data_i = '0;
    endtask

    task automatic load_word(input int which, input int addr, input logic [7:0] val);
        @(negedge clk);
        case (which)
            0: begin bus_a.load_we_i = 1; bus_a.load_addr_i = addr[7:0]; bus_a.load_data_i = val; end
            1: begin bus_b.load_we_i = 1; bus_b.load_addr_i = addr[7:0]; bus_b.load_data_i = val; end
            2: begin bus_c.load_we_i = 1; bus_c.load_addr_i = addr[7:0]; bus_c.load_data_i = val; end
            default: begin bus_d.load_we_i = 1; bus_d.load_addr_i = addr[9:0]; bus_d.load_data_i = val; end
        endcase
        @(negedge clk);
        bus_a.load_we_i = 0; bus_b.load_we_i = 0; bus_c.load_we_i = 0; bus_d.load_we_i = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // T1 image, then reset-state checks
    task automatic test_reset();
        load_word(0, 0, 8'd3); load_word(0, 1, 8'd0);
        load_word(0, 2, 8'h41); load_word(0, 3, 8'h42); load_word(0, 4, 8'h43);
        do_reset();
        checks++; if (bus_a.valid_o !== 1'b1) begin errors++; $display("FAIL reset_valid: got %b want 1", bus_a.valid_o); end
        checks++; if (bus_a.data_o !== 8'h41) begin errors++; $display("FAIL reset_data: got %h want 41", bus_a.data_o); end
        checks++; if (bus_a.done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus_a.done_o); end
        checks++; if (bus_a.count_o !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus_a.count_o); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        exp_q = {8'h41, 8'h42, 8'h43};
        bus_a.read_i = 1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (bus_a.valid_o !== 1'b1 || bus_a.data_o !== exp) begin
                errors++; $display("FAIL b2b_word%0d: got v=%b d=%h want v=1 d=%h", i, bus_a.valid_o, bus_a.data_o, exp);
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus_a.valid_o !== 1'b0 || bus_a.done_o !== 1'b1 || bus_a.data_o !== 8'h00 || bus_a.count_o !== 16'd3) begin
                errors++; $display("FAIL b2b_done%0d: got v=%b done=%b d=%h cnt=%0d want v=0 done=1 d=00 cnt=3",
                                   i, bus_a.valid_o, bus_a.done_o, bus_a.data_o, bus_a.count_o);
            end
        end
        bus_a.read_i = 0;
    endtask

    task automatic test_empty();
        load_word(0, 0, 8'd0); load_word(0, 1, 8'd0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus_a.read_i = (i % 2 == 0);
            checks++;
            if (bus_a.valid_o !== 1'b0 || bus_a.done_o !== 1'b1 || bus_a.data_o !== 8'h00 || bus_a.count_o !== 16'd0) begin
                errors++; $display("FAIL empty_%0d: got v=%b done=%b d=%h cnt=%0d want v=0 done=1 d=00 cnt=0",
                                   i, bus_a.valid_o, bus_a.done_o, bus_a.data_o, bus_a.count_o);
            end
            @(negedge clk);
        end
        bus_a.read_i = 0;
    endtask

    task automatic test_loop();
        logic [7:0] exp;
        load_word(1, 0, 8'd2); load_word(1, 1, 8'd0);
        load_word(1, 2, 8'hAA); load_word(1, 3, 8'h55);
        do_reset();
        exp_q = {8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55};
        bus_b.read_i = 1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (bus_b.valid_o !== 1'b1 || bus_b.data_o !== exp || bus_b.done_o !== 1'b0) begin
                errors++; $display("FAIL loop_word%0d: got v=%b d=%h done=%b want v=1 d=%h done=0",
                                   i, bus_b.valid_o, bus_b.data_o, bus_b.done_o, exp);
            end
        end
        @(negedge clk);
        bus_b.read_i = 0;
        checks++;
        if (bus_b.count_o !== 16'd6 || bus_b.done_o !== 1'b0 || bus_b.data_o !== 8'hAA) begin
            errors++; $display("FAIL loop_end: got cnt=%0d done=%b d=%h want cnt=6 done=0 d=aa",
                               bus_b.count_o, bus_b.done_o, bus_b.data_o);
        end
    endtask

    task automatic test_gaps();
        logic [15:0] lfsr;
        logic [7:0]  exp;
        int exp_gap;
        int cyc;
        for (int i = 0; i < 8; i++) load_word(2, 2 + i, 8'(8'h10 + i));
        load_word(2, 0, 8'd8); load_word(2, 1, 8'd0);
        do_reset();
        lfsr = 16'hACE1;
        exp_gap = 0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'h10 + i));
        bus_c.read_i = 1;
        cyc = 0;
        while (cyc < 300) begin
            if (bus_c.done_o === 1'b1) break;
            if (bus_c.valid_o === 1'b1) begin
                checks++;
                if (exp_gap != 0) begin errors++; $display("FAIL gap_short: got 0 idle left want %0d", exp_gap); end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL gap_extra_word: got %h want none", bus_c.data_o);
                end else begin
                    exp = exp_q.pop_front();
                    if (bus_c.data_o !== exp) begin errors++; $display("FAIL gap_data: got %h want %h", bus_c.data_o, exp); end
                end
                lfsr = ref_lfsr(lfsr);
                exp_gap = (exp_q.size() == 0) ? 0 : int'(lfsr[3:0]);
                exp_gap = 0 + exp_gap;
            end else begin
                checks++;
                if (exp_gap == 0) begin errors++; $display("FAIL gap_long: got valid=0 want valid=1"); end
                else exp_gap--;
            end
            @(negedge clk);
            cyc++;
        end
        bus_c.read_i = 0;
        checks++;
        if (bus_c.done_o !== 1'b1 || bus_c.count_o !== 16'd8 || exp_q.size() != 0) begin
            errors++; $display("FAIL gap_end: got done=%b cnt=%0d left=%0d want done=1 cnt=8 left=0",
                               bus_c.done_o, bus_c.count_o, exp_q.size());
        end
    endtask

    task automatic test_rewind();
        load_word(0, 0, 8'd4); load_word(0, 1, 8'd0);
        for (int i = 0; i < 4; i++) load_word(0, 2 + i, 8'(8'h61 + i));
        do_reset();
        bus_a.read_i = 1;
        checks++; if (bus_a.data_o !== 8'h61) begin errors++; $display("FAIL rew_w0: got %h want 61", bus_a.data_o); end
        @(negedge clk);
        checks++; if (bus_a.data_o !== 8'h62) begin errors++; $display("FAIL rew_w1: got %h want 62", bus_a.data_o); end
        bus_a.rewind_i = 1;
        @(negedge clk);
        bus_a.rewind_i = 0;
        checks++;
        if (bus_a.valid_o !== 1'b1 || bus_a.data_o !== 8'h61 || bus_a.count_o !== 16'd0) begin
            errors++; $display("FAIL rew_stream: got v=%b d=%h cnt=%0d want v=1 d=61 cnt=0",
                               bus_a.valid_o, bus_a.data_o, bus_a.count_o);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (bus_a.done_o !== 1'b1 || bus_a.count_o !== 16'd4) begin
            errors++; $display("FAIL rew_drain: got done=%b cnt=%0d want done=1 cnt=4", bus_a.done_o, bus_a.count_o);
        end
        bus_a.rewind_i = 1;
        @(negedge clk);
        bus_a.rewind_i = 0;
        bus_a.read_i = 0;
        checks++;
        if (bus_a.done_o !== 1'b0 || bus_a.valid_o !== 1'b1 || bus_a.data_o !== 8'h61 || bus_a.count_o !== 16'd0) begin
            errors++; $display("FAIL rew_done: got done=%b v=%b d=%h cnt=%0d want done=0 v=1 d=61 cnt=0",
                               bus_a.done_o, bus_a.valid_o, bus_a.data_o, bus_a.count_o);
        end
    endtask

    task automatic test_reset_mid_gap();
        int cyc;
        do_reset();
        bus_c.read_i = 1;
        cyc = 0;
        while (cyc < 20 && !(bus_c.valid_o === 1'b0 && bus_c.done_o === 1'b0)) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (bus_c.state_o !== ST_GAP) begin errors++; $display("FAIL midgap_enter: got %0d want %0d", bus_c.state_o, ST_GAP); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus_c.valid_o !== 1'b1 || bus_c.data_o !== 8'h10 || bus_c.done_o !== 1'b0 || bus_c.count_o !== 16'd0) begin
            errors++; $display("FAIL midgap_reset: got v=%b d=%h done=%b cnt=%0d want v=1 d=10 done=0 cnt=0",
                               bus_c.valid_o, bus_c.data_o, bus_c.done_o, bus_c.count_o);
        end
        @(negedge clk);
        rst = 1'b0;
        bus_c.read_i = 0;
    endtask

    task automatic test_clip();
        int n;
        int cyc;
        load_word(3, 0, 8'h70); load_word(3, 1, 8'h11); load_word(3, 2, 8'h01);
        load_word(3, 3, 8'h5A); load_word(3, 1023, 8'hC3);
        do_reset();
        bus_d.read_i = 1;
        n = 0;
        cyc = 0;
        while (cyc < 1100 && bus_d.valid_o === 1'b1) begin
            if (n == 0) begin
                checks++; if (bus_d.data_o !== 8'h5A) begin errors++; $display("FAIL clip_first: got %h want 5a", bus_d.data_o); end
            end
            if (n == 1020) begin
                checks++; if (bus_d.data_o !== 8'hC3) begin errors++; $display("FAIL clip_last: got %h want c3", bus_d.data_o); end
            end
            n++;
            @(negedge clk);
            cyc++;
        end
        bus_d.read_i = 0;
        checks++;
        if (n != 1021 || bus_d.done_o !== 1'b1 || bus_d.count_o !== 24'd1021) begin
            errors++; $display("FAIL clip_len: got words=%0d done=%b cnt=%0d want words=1021 done=1 cnt=1021",
                               n, bus_d.done_o, bus_d.count_o);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_back_to_back();
        test_empty();
        test_loop();
        test_gaps();
        test_rewind();
        test_reset_mid_gap();
        test_clip();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
